inst_prefetch: RTL and testbench

Instruction prefetch buffer between the synchronous instruction memory and the core's fetch stage. It owns the fetch PC, streams sequential word reads into a small FIFO, and presents instructions to the fetch stage with a valid/ready handshake. On a taken branch or jump it accepts a redirect, flushes queued and in-flight instructions, and restarts fetching at the new target.

---
 rtl/scc_pkg.sv | 20 ++
 rtl/inst_prefetch_if.sv | 42 ++++
 rtl/inst_fifo.sv | 84 ++++++++
 rtl/inst_prefetch.sv | 80 ++++++++
 tb/tb_inst_prefetch.sv | 242 ++++++++++++++++++++++++
 5 files changed

// File: rtl/scc_pkg.sv
// Shared widths, defaults and the FIFO entry type for the instruction
// prefetch path.
package scc_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned INST_W = 32;
    localparam logic [ADDR_W-1:0] PC_STEP = 32'd4;
    localparam logic [ADDR_W-1:0] RESET_PC_DFLT = 32'h0000_0000;

    typedef struct packed {
        logic [ADDR_W-1:0] pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

    // Instructions are word aligned; the low address bits are dropped.
    function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] pc);
        return {pc[ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/inst_prefetch_if.sv
// Instruction-memory read port, redirect request and fetch-stage handshake
// grouped as one bundle; master is the prefetch buffer.
interface inst_prefetch_if;
    import scc_pkg::*;

    logic [ADDR_W-1:0] in_mem_addr;
    logic              in_mem_en;
    logic [INST_W-1:0] in_mem;

    logic              redirect;
    logic [ADDR_W-1:0] redirect_pc;

    logic              inst_valid;
    logic [INST_W-1:0] inst;
    logic [ADDR_W-1:0] inst_pc;
    logic              inst_ready;

    modport master (
        output in_mem_addr,
        output in_mem_en,
        input  in_mem,
        input  redirect,
        input  redirect_pc,
        output inst_valid,
        output inst,
        output inst_pc,
        input  inst_ready
    );

    modport slave (
        input  in_mem_addr,
        input  in_mem_en,
        output in_mem,
        output redirect,
        output redirect_pc,
        input  inst_valid,
        input  inst,
        input  inst_pc,
        output inst_ready
    );

endinterface

// File: rtl/inst_fifo.sv
// Synchronous FIFO of {pc, inst} entries with push, pop, flush and occupancy.
// Flush wins over push/pop in the same cycle.
module inst_fifo import scc_pkg::*; #(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  fetch_entry_t     push_data_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output fetch_entry_t     head_o,
    output logic             valid_o,
    output logic [CNT_W-1:0] count_o
);

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("inst_fifo: DEPTH must be a power of two and at least 2");
    end

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        do_push  = push_i && !flush_i;
        do_pop   = pop_i && !flush_i && (count_q != '0);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (do_pop && !do_push) begin
                count_d = count_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only visible while count_q covers them.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    always_comb begin
        head_o  = mem_q[rd_ptr_q];
        valid_o = (count_q != '0);
        count_o = count_q;
    end

    a_no_overflow : assert property (@(posedge clk) disable iff (!reset)
        !(do_push && !do_pop && count_q == FULL_CNT));

endmodule

// File: rtl/inst_prefetch.sv
// Instruction prefetch buffer: owns the fetch PC, streams sequential reads
// into a small FIFO under a credit check, and flushes on redirect.
module inst_prefetch import scc_pkg::*; #(
    parameter int unsigned       DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DFLT
) (
    input logic            clk,
    input logic            reset,
    inst_prefetch_if.master bus
);

    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);
    localparam int unsigned USED_W = CNT_W + 1;
    localparam logic [USED_W-1:0] CREDITS = USED_W'(DEPTH);

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] in_flight_pc_q, in_flight_pc_d;
    logic              in_flight_q, in_flight_d;

    logic              issue, push, pop;
    logic [USED_W-1:0] used;
    fetch_entry_t      push_data, head;
    logic              fifo_valid;
    logic [CNT_W-1:0]  count;

    // Queued plus in-flight words must fit, so a returning read always has a slot.
    always_comb begin
        used      = {1'b0, count} + {{CNT_W{1'b0}}, in_flight_q};
        issue     = !bus.redirect && (used < CREDITS);
        push      = in_flight_q && !bus.redirect;
        pop       = fifo_valid && bus.inst_ready && !bus.redirect;
        push_data = '{pc: in_flight_pc_q, inst: bus.in_mem};

        fetch_pc_d     = fetch_pc_q;
        in_flight_pc_d = in_flight_pc_q;
        in_flight_d    = issue;
        if (bus.redirect) begin
            fetch_pc_d = align_pc(bus.redirect_pc);
        end else if (issue) begin
            fetch_pc_d     = fetch_pc_q + PC_STEP;
            in_flight_pc_d = fetch_pc_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc_q     <= RESET_PC;
            in_flight_q    <= 1'b0;
            in_flight_pc_q <= '0;
        end else begin
            fetch_pc_q     <= fetch_pc_d;
            in_flight_q    <= in_flight_d;
            in_flight_pc_q <= in_flight_pc_d;
        end
    end

    inst_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (push),
        .push_data_i (push_data),
        .pop_i       (pop),
        .flush_i     (bus.redirect),
        .head_o      (head),
        .valid_o     (fifo_valid),
        .count_o     (count)
    );

    // The read strobe is held off combinationally while reset is asserted.
    always_comb begin
        bus.in_mem_addr = fetch_pc_q;
        bus.in_mem_en   = issue && reset;
        bus.inst_valid  = fifo_valid;
        bus.inst        = fifo_valid ? head.inst : '0;
        bus.inst_pc     = fifo_valid ? head.pc : '0;
    end

endmodule

// File: tb/tb_inst_prefetch.sv
// Directed bench for inst_prefetch: expected deliveries go into per-DUT queues
// and a negedge monitor pops and compares on every accepted handshake.
module tb_inst_prefetch;
    import scc_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    logic [31:0] exp0[$];
    logic [31:0] exp1[$];

    always #5 clk = ~clk;

    inst_prefetch_if bus0 ();
    inst_prefetch_if bus1 ();

    inst_prefetch #(
        .DEPTH    (4),
        .RESET_PC (32'h0000_0000)
    ) dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0.master)
    );

    inst_prefetch #(
        .DEPTH    (4),
        .RESET_PC (32'hFFFF_FFF8)
    ) dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1.master)
    );

    // Memory model: word = address, returned one cycle after the strobe.
    always @(posedge clk) begin
        if (bus0.in_mem_en) bus0.in_mem <= bus0.in_mem_addr;
        if (bus1.in_mem_en) bus1.in_mem <= bus1.in_mem_addr;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    always @(negedge clk) begin : mon0
        logic [31:0] e;
        if (reset && bus0.inst_valid && bus0.inst_ready && !bus0.redirect) begin
            if (exp0.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL dut0_unexpected: got pc %h, required no delivery", bus0.inst_pc);
            end else begin
                e = exp0.pop_front();
                check("dut0_pc", bus0.inst_pc, e);
                check("dut0_inst", bus0.inst, e);
            end
        end
    end

    always @(negedge clk) begin : mon1
        logic [31:0] e;
        if (reset && bus1.inst_valid && bus1.inst_ready && !bus1.redirect) begin
            if (exp1.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL dut1_unexpected: got pc %h, required no delivery", bus1.inst_pc);
            end else begin
                e = exp1.pop_front();
                check("dut1_pc", bus1.inst_pc, e);
                check("dut1_inst", bus1.inst, e);
            end
        end
    end

    initial begin
        bus0.redirect    = 1'b0;
        bus0.redirect_pc = '0;
        bus0.inst_ready  = 1'b0;
        bus1.redirect    = 1'b0;
        bus1.redirect_pc = '0;
        bus1.inst_ready  = 1'b0;

        // Reset values
        repeat (3) tick();
        sample();
        check("rst_en", 32'(bus0.in_mem_en), 32'd0);
        check("rst_addr", bus0.in_mem_addr, 32'h0);
        check("rst_valid", 32'(bus0.inst_valid), 32'd0);
        check("rst_inst", bus0.inst, 32'h0);
        check("rst_pc", bus0.inst_pc, 32'h0);
        check("rst_addr1", bus1.in_mem_addr, 32'hFFFF_FFF8);

        // Streaming from reset with inst_ready high; dut1 exercises the PC wrap
        tick();
        reset = 1'b1;
        bus0.inst_ready = 1'b1;
        bus1.inst_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            exp0.push_back(32'(4 * k));
            exp1.push_back(32'hFFFF_FFF8 + 32'(4 * k));
        end
        for (int i = 0; i < 10; i++) begin
            sample();
            check("stream_en", 32'(bus0.in_mem_en), 32'd1);
            check("stream_addr", bus0.in_mem_addr, 32'(4 * i));
            check("stream_valid", 32'(bus0.inst_valid), 32'(i >= 2));
            if (i < 4) check("wrap_addr", bus1.in_mem_addr, 32'hFFFF_FFF8 + 32'(4 * i));
            tick();
        end
        bus0.inst_ready = 1'b0;
        bus1.inst_ready = 1'b0;
        sample();
        check("stream_drained", 32'(exp0.size()), 32'd0);
        check("wrap_drained", 32'(exp1.size()), 32'd0);

        // Asynchronous reset while the buffer is busy
        repeat (3) tick();
        check("busy_valid", 32'(bus0.inst_valid), 32'd1);
        reset = 1'b0;
        #1;
        check("arst_en", 32'(bus0.in_mem_en), 32'd0);
        check("arst_addr", bus0.in_mem_addr, 32'h0);
        check("arst_valid", 32'(bus0.inst_valid), 32'd0);
        check("arst_inst", bus0.inst, 32'h0);
        check("arst_pc", bus0.inst_pc, 32'h0);

        // Back-pressure from reset: four issues, then stall until ready rises
        tick();
        tick();
        reset = 1'b1;
        for (int i = 0; i < 8; i++) begin
            sample();
            check("full_en", 32'(bus0.in_mem_en), 32'(i < 4));
            check("full_addr", bus0.in_mem_addr, (i < 4) ? 32'(4 * i) : 32'h10);
            if (i == 7) begin
                check("full_valid", 32'(bus0.inst_valid), 32'd1);
                check("full_head", bus0.inst_pc, 32'h0);
            end
            tick();
        end
        bus0.inst_ready = 1'b1;
        for (int k = 0; k < 6; k++) exp0.push_back(32'(4 * k));
        for (int j = 0; j < 6; j++) begin
            sample();
            if (j == 0) check("resume_en0", 32'(bus0.in_mem_en), 32'd0);
            if (j == 1) begin
                check("resume_en1", 32'(bus0.in_mem_en), 32'd1);
                check("resume_addr", bus0.in_mem_addr, 32'h10);
            end
            tick();
        end
        bus0.inst_ready = 1'b0;
        sample();
        check("resume_drained", 32'(exp0.size()), 32'd0);

        // Redirect with three queued entries and a read in flight
        tick();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        repeat (4) tick();
        bus0.redirect    = 1'b1;
        bus0.redirect_pc = 32'h0000_0103;
        bus0.inst_ready  = 1'b1;
        sample();
        check("redir_en", 32'(bus0.in_mem_en), 32'd0);
        check("redir_pre_valid", 32'(bus0.inst_valid), 32'd1);
        tick();
        bus0.redirect = 1'b0;
        for (int k = 0; k < 4; k++) exp0.push_back(32'h100 + 32'(4 * k));
        sample();
        check("redir_r1_en", 32'(bus0.in_mem_en), 32'd1);
        check("redir_r1_addr", bus0.in_mem_addr, 32'h100);
        check("redir_r1_valid", 32'(bus0.inst_valid), 32'd0);
        tick();
        sample();
        check("redir_r2_valid", 32'(bus0.inst_valid), 32'd0);
        check("redir_r2_addr", bus0.in_mem_addr, 32'h104);
        tick();
        sample();
        check("redir_r3_valid", 32'(bus0.inst_valid), 32'd1);
        check("redir_r3_pc", bus0.inst_pc, 32'h100);
        repeat (3) tick();
        tick();
        bus0.inst_ready = 1'b0;
        sample();
        check("redir_drained", 32'(exp0.size()), 32'd0);

        // Back-to-back redirects: the second target wins
        tick();
        bus0.redirect    = 1'b1;
        bus0.redirect_pc = 32'h0000_0200;
        sample();
        check("b2b_en0", 32'(bus0.in_mem_en), 32'd0);
        tick();
        bus0.redirect_pc = 32'h0000_0300;
        sample();
        check("b2b_en1", 32'(bus0.in_mem_en), 32'd0);
        tick();
        bus0.redirect   = 1'b0;
        bus0.inst_ready = 1'b1;
        for (int k = 0; k < 3; k++) exp0.push_back(32'h300 + 32'(4 * k));
        sample();
        check("b2b_en", 32'(bus0.in_mem_en), 32'd1);
        check("b2b_addr", bus0.in_mem_addr, 32'h300);
        check("b2b_r1_valid", 32'(bus0.inst_valid), 32'd0);
        tick();
        sample();
        check("b2b_r2_valid", 32'(bus0.inst_valid), 32'd0);
        tick();
        sample();
        check("b2b_r3_valid", 32'(bus0.inst_valid), 32'd1);
        check("b2b_r3_pc", bus0.inst_pc, 32'h300);
        tick();
        tick();
        tick();
        bus0.inst_ready = 1'b0;
        sample();
        check("b2b_drained", 32'(exp0.size()), 32'd0);

        repeat (2) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
